// File: rtl/rvv_issue_sched.sv
// Issue scheduler for the RVV datapath: buffers OP-V words, tracks pending vector
// register writes and issues one hazard-free instruction at a time, serialising OPCFG.
module rvv_issue_sched #(
    parameter int INSN_WIDTH = 32,
    parameter int NUM_VEC    = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [INSN_WIDTH-1:0] insn_in,
    input  logic                  insn_valid,
    output logic                  insn_ready,
    output logic [INSN_WIDTH-1:0] issue_insn,
    output logic                  issue_valid,
    input  logic                  issue_ready,
    input  logic                  wb_valid,
    input  logic [4:0]            wb_vd,
    output logic                  drop_pulse,
    output logic [NUM_VEC-1:0]    busy_vec,
    output logic                  idle,
    output logic                  state_dbg
);
    localparam int PW = $clog2(FIFO_DEPTH);

    typedef enum logic {RUN = 1'b0, CFG_WAIT = 1'b1} state_t;

    // Handshakes: a word moves on insn_* or issue_* only in a cycle where valid
    // and ready are both high at the rising edge; the source holds its word
    // stable while valid is high and ready is low.

    state_t                 state, state_nxt;
    logic [INSN_WIDTH-1:0]  fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]          wr_ptr, rd_ptr;
    logic [PW:0]            count;
    logic [INSN_WIDTH-1:0]  head;
    logic                   head_valid, fifo_full;
    logic                   in_opv, push, drop_acc, load;
    logic [4:0]             h_vd, h_vs1, h_vs2;
    logic [2:0]             h_f3;
    logic                   h_vm, rd_vs1, rd_vs2, is_cfg, hazard;
    logic                   reg_free, cfg_block;
    logic [NUM_VEC-1:0]     wb_mask, busy_byp, busy_nxt;

    assign fifo_full  = (count == (PW+1)'(FIFO_DEPTH));
    assign head_valid = (count != '0);
    assign insn_ready = !fifo_full;
    assign in_opv     = (insn_in[6:0] == 7'h57);
    assign push       = insn_valid && insn_ready && in_opv;
    assign drop_acc   = insn_valid && insn_ready && !in_opv;

    assign head   = fifo_mem[rd_ptr];
    assign h_vd   = head[11:7];
    assign h_f3   = head[14:12];
    assign h_vs1  = head[19:15];
    assign h_vs2  = head[24:20];
    assign h_vm   = head[25];
    assign rd_vs1 = (h_f3 <= 3'd2);
    assign rd_vs2 = (h_f3 != 3'd7);
    assign is_cfg = (h_f3 == 3'd7);

    // A writeback landing this cycle already releases its register for the hazard check.
    assign wb_mask  = wb_valid ? (NUM_VEC'(1) << wb_vd) : '0;
    assign busy_byp = busy_vec & ~wb_mask;
    assign hazard   = busy_byp[h_vd] | (rd_vs2 & busy_byp[h_vs2]) |
                      (rd_vs1 & busy_byp[h_vs1]) | (!h_vm & busy_byp[0]);

    assign reg_free  = !issue_valid || issue_ready;
    assign cfg_block = (busy_vec != '0) || issue_valid;

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        case (state)
            RUN: begin
                if (head_valid) begin
                    if (is_cfg && cfg_block) state_nxt = CFG_WAIT;
                    else if (!hazard && reg_free) load = 1'b1;
                end
            end
            CFG_WAIT: begin
                if (head_valid && !cfg_block) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    // Set beats clear when an issue and a writeback target the same register.
    always_comb begin
        busy_nxt = busy_vec & ~wb_mask;
        if (load && !is_cfg) busy_nxt[h_vd] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= insn_in;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= RUN;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            issue_valid <= 1'b0;
            issue_insn  <= '0;
            busy_vec    <= '0;
            drop_pulse  <= 1'b0;
        end else begin
            state      <= state_nxt;
            drop_pulse <= drop_acc;
            busy_vec   <= busy_nxt;
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (load) rd_ptr <= rd_ptr + PW'(1);
            count <= count + (PW+1)'(push) - (PW+1)'(load);
            if (load) begin
                issue_valid <= 1'b1;
                issue_insn  <= head;
            end else if (issue_ready) begin
                issue_valid <= 1'b0;
            end
        end
    end

    assign idle      = !head_valid && !issue_valid && (busy_vec == '0);
    assign state_dbg = (state == CFG_WAIT);

endmodule

// File: tb/tb_rvv_issue_sched.sv
// Bench for rvv_issue_sched: directed scenarios plus randomized traffic, with an
// in-order expected-issue queue and a pending-write set as the reference model.
module tb_rvv_issue_sched;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] insn_in = '0;
    logic        insn_valid = 1'b0;
    logic        insn_ready;
    logic [31:0] issue_insn;
    logic        issue_valid;
    logic        issue_ready = 1'b0;
    logic        wb_valid = 1'b0;
    logic [4:0]  wb_vd = '0;
    logic        drop_pulse;
    logic [31:0] busy_vec;
    logic        idle;
    logic        state_dbg;

    rvv_issue_sched dut (
        .clk(clk), .rst(rst_n), .insn_in(insn_in), .insn_valid(insn_valid),
        .insn_ready(insn_ready), .issue_insn(issue_insn), .issue_valid(issue_valid),
        .issue_ready(issue_ready), .wb_valid(wb_valid), .wb_vd(wb_vd),
        .drop_pulse(drop_pulse), .busy_vec(busy_vec), .idle(idle), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass = 0;
    int          drop_exp = 0;
    int          drop_seen = 0;
    logic [31:0] exp_q[$];
    logic [31:0] pending = '0;

    localparam logic [31:0] CFG_W = 32'h80007057;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [31:0] mk(input logic [2:0] f3, input logic [4:0] vd,
                                       input logic [4:0] vs1, input logic [4:0] vs2,
                                       input logic vm);
        return {6'b010111, vm, vs2, vs1, f3, vd, 7'h57};
    endfunction

    // Registers an instruction depends on, straight from the decode rules.
    function automatic logic [31:0] haz_mask(input logic [31:0] w);
        logic [31:0] m;
        m = 32'h0;
        m[w[11:7]] = 1'b1;
        if (w[14:12] != 3'd7) m[w[24:20]] = 1'b1;
        if (w[14:12] <= 3'd2) m[w[19:15]] = 1'b1;
        if (!w[25]) m[0] = 1'b1;
        return m;
    endfunction

    // Monitor: every issue handshake pops the expected queue in order.
    always @(negedge clk) begin
        logic [31:0] w;
        #2;
        if (rst_n && issue_valid && issue_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL issue_unexpected: got %h expected no issue", issue_insn);
            end else begin
                w = exp_q.pop_front();
                check("issue_order", issue_insn, w);
                if (w[14:12] == 3'd7) check("cfg_with_pending", pending, 32'h0);
                else begin
                    check("issue_hazard", pending & haz_mask(w), 32'h0);
                    pending[w[11:7]] = 1'b1;
                end
            end
        end
        if (rst_n && drop_pulse) drop_seen++;
    end

    task automatic step(input logic v, input logic [31:0] w, input logic rdy,
                        input logic wbv, input logic [4:0] wvd, output logic acc);
        @(negedge clk);
        insn_valid = v; insn_in = w; issue_ready = rdy; wb_valid = wbv; wb_vd = wvd;
        #1;
        acc = insn_valid && insn_ready;
        if (acc) begin
            if (insn_in[6:0] == 7'h57) exp_q.push_back(insn_in);
            else drop_exp++;
        end
        if (wb_valid) pending[wb_vd] = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        logic       acc;
        logic       done;
        logic [4:0] vd;
        done = 1'b0;
        for (int c = 0; c < 400 && !done; c++) begin
            vd = '0;
            for (int i = 31; i >= 0; i--) if (pending[i]) vd = 5'(i);
            step(1'b0, 32'h0, 1'b1, pending != 0, vd, acc);
            if (exp_q.size() == 0 && pending == 0 && idle) done = 1'b1;
        end
        check("drain_done", 32'(done), 32'h1);
    endtask

    function automatic logic [31:0] rand_word();
        int unsigned r;
        logic [31:0] w;
        r = $urandom_range(0, 99);
        if (r < 10) begin
            w = $urandom;
            if (w[6:0] == 7'h57) w[0] = ~w[0];
        end else if (r < 16) begin
            w = $urandom;
            w[6:0] = 7'h57;
            w[14:12] = 3'd7;
        end else begin
            w = mk(3'($urandom_range(0, 6)), 5'($urandom_range(0, 7)),
                   5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
        end
        return w;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("%0d/%0d checks passed", n_pass, n_checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic        acc;
        logic [31:0] ins[6];
        logic        cur_v;
        logic [31:0] cur_w;
        logic        wbv;
        logic [4:0]  wvd;
        int          k, tries, nset;

        repeat (2) @(negedge clk);
        check("rst_idle", 32'(idle), 32'h1);
        check("rst_insn_ready", 32'(insn_ready), 32'h1);
        check("rst_issue_valid", 32'(issue_valid), 32'h0);
        check("rst_issue_insn", issue_insn, 32'h0);
        check("rst_busy", busy_vec, 32'h0);
        check("rst_drop", 32'(drop_pulse), 32'h0);
        check("rst_state", 32'(state_dbg), 32'h0);
        rst_n = 1'b1;

        // Single instruction: latency, scoreboard set and clear.
        step(1'b1, 32'h5c0000d7, 1'b1, 1'b0, 5'd0, acc);
        check("lat_not_yet", 32'(issue_valid), 32'h0);
        step(1'b0, 32'h0, 1'b1, 1'b0, 5'd0, acc);
        check("lat_valid", 32'(issue_valid), 32'h1);
        check("lat_insn", issue_insn, 32'h5c0000d7);
        check("lat_busy", busy_vec, 32'h2);
        step(1'b0, 32'h0, 1'b1, 1'b0, 5'd0, acc);
        check("t1_busy_hold", busy_vec, 32'h2);
        check("t1_not_idle", 32'(idle), 32'h0);
        step(1'b0, 32'h0, 1'b1, 1'b1, 5'd1, acc);
        check("t1_busy_clear", busy_vec, 32'h0);
        check("t1_idle", 32'(idle), 32'h1);

        // RAW on v1 with writeback bypass.
        step(1'b1, 32'h5c0000d7, 1'b1, 1'b0, 5'd0, acc);
        step(1'b1, 32'h5c0081d7, 1'b1, 1'b0, 5'd0, acc);
        step(1'b0, 32'h0, 1'b1, 1'b0, 5'd0, acc);
        check("raw_held", 32'(issue_valid), 32'h0);
        step(1'b0, 32'h0, 1'b1, 1'b0, 5'd0, acc);
        check("raw_still_held", 32'(issue_valid), 32'h0);
        step(1'b0, 32'h0, 1'b1, 1'b1, 5'd1, acc);
        check("raw_bypass_valid", 32'(issue_valid), 32'h1);
        check("raw_bypass_insn", issue_insn, 32'h5c0081d7);
        check("raw_busy", busy_vec, 32'h8);
        step(1'b0, 32'h0, 1'b1, 1'b0, 5'd0, acc);
        drain();

        // Non-OP-V words are swallowed.
        step(1'b1, 32'habcef012, 1'b1, 1'b0, 5'd0, acc);
        check("drop1_acc", 32'(acc), 32'h1);
        check("drop1_pulse", 32'(drop_pulse), 32'h1);
        step(1'b1, 32'h98765432, 1'b1, 1'b0, 5'd0, acc);
        check("drop2_pulse", 32'(drop_pulse), 32'h1);
        step(1'b0, 32'h0, 1'b1, 1'b0, 5'd0, acc);
        check("drop_pulse_end", 32'(drop_pulse), 32'h0);
        check("drop_no_issue", 32'(issue_valid), 32'h0);
        check("drop_busy", busy_vec, 32'h0);

        // Backpressure: 4 FIFO entries + issue register, then in-order drain.
        for (int i = 0; i < 6; i++) ins[i] = mk(3'd0, 5'(8 + i), 5'd20, 5'd21, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tries = 0;
            acc = 1'b0;
            while (!acc && tries < 10) begin
                step(1'b1, ins[i], 1'b0, 1'b0, 5'd0, acc);
                tries++;
            end
            check("bp_push_acc", 32'(acc), 32'h1);
        end
        check("bp_full", 32'(insn_ready), 32'h0);
        step(1'b1, ins[5], 1'b0, 1'b0, 5'd0, acc);
        check("bp_blocked", 32'(acc), 32'h0);
        check("bp_stable", issue_insn, ins[0]);
        step(1'b1, ins[5], 1'b0, 1'b0, 5'd0, acc);
        check("bp_stable2", issue_insn, ins[0]);
        cur_v = 1'b1;
        for (int i = 1; i < 6; i++) begin
            step(cur_v, ins[5], 1'b1, 1'b0, 5'd0, acc);
            if (acc) cur_v = 1'b0;
            check("bp_stream_valid", 32'(issue_valid), 32'h1);
            check("bp_stream_insn", issue_insn, ins[i]);
        end
        step(1'b0, 32'h0, 1'b1, 1'b0, 5'd0, acc);
        check("bp_stream_end", 32'(issue_valid), 32'h0);
        drain();

        // OPCFG waits for the scoreboard to empty.
        ins[0] = mk(3'd0, 5'd2, 5'd20, 5'd21, 1'b1);
        ins[1] = mk(3'd0, 5'd5, 5'd20, 5'd21, 1'b1);
        step(1'b1, ins[0], 1'b1, 1'b0, 5'd0, acc);
        step(1'b0, 32'h0, 1'b1, 1'b0, 5'd0, acc);
        step(1'b1, CFG_W, 1'b1, 1'b0, 5'd0, acc);
        step(1'b1, ins[1], 1'b1, 1'b0, 5'd0, acc);
        step(1'b0, 32'h0, 1'b1, 1'b0, 5'd0, acc);
        check("cfg_wait_state", 32'(state_dbg), 32'h1);
        check("cfg_wait_no_issue", 32'(issue_valid), 32'h0);
        step(1'b0, 32'h0, 1'b1, 1'b1, 5'd2, acc);
        check("cfg_after_wb", 32'(issue_valid), 32'h0);
        step(1'b0, 32'h0, 1'b1, 1'b0, 5'd0, acc);
        check("cfg_issued", issue_insn, CFG_W);
        check("cfg_back_run", 32'(state_dbg), 32'h0);
        step(1'b0, 32'h0, 1'b1, 1'b0, 5'd0, acc);
        check("cfg_follower", issue_insn, ins[1]);
        check("cfg_follower_busy", busy_vec, 32'h20);
        drain();

        // Asynchronous reset with work in flight.
        for (int i = 0; i < 3; i++) step(1'b1, mk(3'd0, 5'(14 + i), 5'd20, 5'd21, 1'b1), 1'b0, 1'b0, 5'd0, acc);
        check("pre_rst_busy", busy_vec, 32'h4000);
        @(negedge clk);
        insn_valid = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        check("arst_issue_valid", 32'(issue_valid), 32'h0);
        check("arst_busy", busy_vec, 32'h0);
        check("arst_idle", 32'(idle), 32'h1);
        check("arst_ready", 32'(insn_ready), 32'h1);
        check("arst_insn", issue_insn, 32'h0);
        exp_q.delete();
        pending = '0;
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 32'h0, 1'b1, 1'b1, 5'd14, acc);
        check("post_rst_wb_busy", busy_vec, 32'h0);
        check("post_rst_idle", 32'(idle), 32'h1);

        // Randomized traffic.
        cur_v = 1'b0;
        cur_w = '0;
        for (int c = 0; c < 1500; c++) begin
            if (!cur_v && $urandom_range(0, 99) < 70) begin
                cur_v = 1'b1;
                cur_w = rand_word();
            end
            wbv = 1'b0;
            wvd = '0;
            if (pending != 0 && $urandom_range(0, 1) == 1) begin
                nset = 0;
                for (int i = 0; i < 32; i++) if (pending[i]) nset++;
                k = int'($urandom_range(0, nset - 1));
                for (int i = 0; i < 32; i++) begin
                    if (pending[i]) begin
                        if (k == 0) begin
                            wbv = 1'b1;
                            wvd = 5'(i);
                        end
                        k--;
                    end
                end
            end
            step(cur_v, cur_w, $urandom_range(0, 3) != 0, wbv, wvd, acc);
            if (acc) cur_v = 1'b0;
        end
        drain();
        step(1'b0, 32'h0, 1'b1, 1'b0, 5'd0, acc);

        check("final_queue_empty", 32'(exp_q.size()), 32'h0);
        check("final_drops", 32'(drop_seen), 32'(drop_exp));
        check("final_busy", busy_vec, 32'h0);
        check("final_idle", 32'(idle), 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
